// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared types and constants
// for the frequency meter slice.
package freq_meter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_COUNT,
    S_DIVIDE,
    S_DONE
  } state_t;

  localparam int unsigned SYS_CLK_HZ = 100_000_000;
  localparam int unsigned FREQ_MAX   = 4095;

endpackage

// File: rtl/freq_meter_divider.sv
// seq_divider: restoring unsigned divider,
// one quotient bit per cycle, W cycles total.
module seq_divider
  import freq_meter_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic         o_done,
  output logic [W-1:0] o_quot
);

  localparam int unsigned LW = $clog2(W) + 1;

  logic [W-1:0]  r_rem;
  logic [W-1:0]  r_q;
  logic [W-1:0]  r_div;
  logic [LW-1:0] r_left;
  logic          r_busy;
  logic          r_done;

  logic [W-1:0]  w_src_rem;
  logic [W-1:0]  w_src_q;
  logic [W-1:0]  w_d;
  logic [W:0]    w_sh;
  logic [W:0]    w_diff;
  logic          w_ge;
  logic [W-1:0]  w_rem_n;
  logic [W-1:0]  w_q_n;

  // one restoring step; the start cycle steps on the fresh operands
  always_comb begin
    w_src_rem = i_start ? '0 : r_rem;
    w_src_q   = i_start ? i_dividend : r_q;
    w_d       = i_start ? i_divisor : r_div;
    w_sh      = {w_src_rem, w_src_q[W-1]};
    w_diff    = w_sh - {1'b0, w_d};
    w_ge      = (w_sh >= {1'b0, w_d});
    w_rem_n   = w_ge ? w_diff[W-1:0] : w_sh[W-1:0];
    w_q_n     = {w_src_q[W-2:0], w_ge};
  end

  // iteration state; done pulses once the last bit is in
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem  <= '0;
      r_q    <= '0;
      r_div  <= '0;
      r_left <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_rem_n;
        r_q    <= w_q_n;
        r_div  <= i_divisor;
        r_left <= LW'(W - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= w_rem_n;
        r_q    <= w_q_n;
        r_left <= r_left - LW'(1);
        if (r_left == LW'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_quot = r_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: period-counting frequency meter,
// reports CLK_HZ / period with overrange and timeout flags.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned CLK_HZ  = SYS_CLK_HZ,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned FREQ_W  = $clog2(FREQ_MAX + 1),
  parameter int unsigned TIMEOUT = 200_000_000
) (
  input  logic              CLOCK,
  input  logic              reset_n,
  input  logic              sig_in,
  input  logic              enable,
  output logic [FREQ_W-1:0] freq_hz,
  output logic              valid,
  output logic              overrange,
  output logic              timeout,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DIVIDEND = CNT_W'(CLK_HZ);

  state_t             r_state;
  state_t             w_nstate;
  logic [2:0]         r_sync;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_period;
  logic [CNT_W-1:0]   r_to;
  logic               r_start;
  logic [FREQ_W-1:0]  r_freq;
  logic               r_valid;
  logic               r_ovr;
  logic               r_tmo;

  logic               w_edge;
  logic               w_live;
  logic               w_to_exp;
  logic               w_close;
  logic               w_ld_div;
  logic               w_ld_to;
  logic               w_done;
  logic [CNT_W-1:0]   w_quot;

  assign w_edge   = r_sync[1] & ~r_sync[2];
  assign w_live   = (r_state == S_ARM) || (r_state == S_COUNT);
  assign w_to_exp = w_live && (r_to == TO_LAST);
  assign w_close  = enable && (r_state == S_COUNT) && w_edge;

  // two-flop synchronizer plus one delayed copy for edge detect
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[1:0], sig_in};
  end

  // state register
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_nstate;
  end

  // next state; an edge beats a coincident timeout
  always_comb begin
    w_nstate = r_state;
    w_ld_div = 1'b0;
    w_ld_to  = 1'b0;
    if (!enable) begin
      w_nstate = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:   w_nstate = S_ARM;
        S_ARM: begin
          if (w_edge) begin
            w_nstate = S_COUNT;
          end else if (w_to_exp) begin
            w_ld_to = 1'b1;
          end
        end
        S_COUNT: begin
          if (w_edge) begin
            w_nstate = S_DIVIDE;
          end else if (w_to_exp) begin
            w_ld_to  = 1'b1;
            w_nstate = S_ARM;
          end
        end
        S_DIVIDE: begin
          if (w_done) begin
            w_ld_div = 1'b1;
            w_nstate = S_DONE;
          end
        end
        S_DONE:   w_nstate = S_ARM;
        default:  w_nstate = S_IDLE;
      endcase
    end
  end

  // period and timeout counters, both saturating
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_period <= '0;
      r_to     <= '0;
      r_start  <= 1'b0;
    end else begin
      r_start <= w_close;
      if (!w_live || !enable || w_edge || w_to_exp) begin
        r_to <= '0;
      end else if (r_to != '1) begin
        r_to <= r_to + CNT_W'(1);
      end
      if (r_state == S_ARM && w_edge) begin
        r_cnt <= '0;
      end else if (r_state == S_COUNT && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_close) r_period <= r_cnt + CNT_W'(1);
    end
  end

  seq_divider #(
    .W (CNT_W)
  ) u_div (
    .i_clk      (CLOCK),
    .i_rst_n    (reset_n),
    .i_clr      (~enable),
    .i_start    (r_start),
    .i_dividend (DIVIDEND),
    .i_divisor  (r_period),
    .o_done     (w_done),
    .o_quot     (w_quot)
  );

  // result registers; held until the next quotient or timeout
  always_ff @(posedge CLOCK or negedge reset_n) begin
    if (!reset_n) begin
      r_freq  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_ld_div) begin
        r_valid <= 1'b1;
        r_tmo   <= 1'b0;
        if (|w_quot[CNT_W-1:FREQ_W]) begin
          r_freq <= '1;
          r_ovr  <= 1'b1;
        end else begin
          r_freq <= w_quot[FREQ_W-1:0];
          r_ovr  <= 1'b0;
        end
      end else if (w_ld_to) begin
        r_valid <= 1'b1;
        r_freq  <= '0;
        r_ovr   <= 1'b0;
        r_tmo   <= 1'b1;
      end
    end
  end

  assign freq_hz   = r_freq;
  assign valid     = r_valid;
  assign overrange = r_ovr;
  assign timeout   = r_tmo;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: square waves of known period
// against floor(CLK/period) with saturation and timeouts.
module tb_freq_meter;

  localparam int CLK = 50_000;
  localparam int TO  = 1000;

  logic        CLOCK;
  logic        reset_n;
  logic        sig_in;
  logic        enable;
  logic [11:0] freq_hz;
  logic        valid;
  logic        overrange;
  logic        timeout;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int nval     = 0;
  int last_rise = -1000;
  bit rises[int];
  bit wave_on  = 0;
  int per      = 2;
  int hi       = 1;
  int ph       = 0;

  freq_meter #(
    .CLK_HZ  (CLK),
    .CNT_W   (32),
    .FREQ_W  (12),
    .TIMEOUT (TO)
  ) dut (
    .CLOCK     (CLOCK),
    .reset_n   (reset_n),
    .sig_in    (sig_in),
    .enable    (enable),
    .freq_hz   (freq_hz),
    .valid     (valid),
    .overrange (overrange),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // drive the wave at negedge, sample outputs just after posedge
  task automatic step();
    logic nx;
    @(negedge CLOCK);
    if (wave_on) begin
      nx = (ph < hi);
      if (nx && !sig_in) begin
        last_rise = cyc;
        rises[cyc] = 1'b1;
      end
      sig_in = nx;
      ph = (ph + 1 == per) ? 0 : ph + 1;
    end
    @(posedge CLOCK);
    #1;
    cyc++;
    if (valid) nval++;
  endtask

  task automatic run_meas(input int p, input int nwant);
    int got;
    int q;
    int budget;
    enable  = 1'b0;
    wave_on = 1'b0;
    sig_in  = 1'b0;
    step();
    step();
    rises.delete();
    per = p;
    hi  = p / 2;
    ph  = 0;
    wave_on = 1'b1;
    enable  = 1'b1;
    q = CLK / p;
    got = 0;
    budget = 6 * p + 200;
    while (got < nwant && budget > 0) begin
      step();
      budget--;
      if (valid) begin
        got++;
        chk($sformatf("freq_p%0d", p), freq_hz, (q > 4095) ? 4095 : q);
        chk($sformatf("ovr_p%0d", p), overrange, (q > 4095) ? 1 : 0);
        chk($sformatf("tmo_p%0d", p), timeout, 0);
        chk($sformatf("lat_p%0d", p), rises.exists(cyc - 36), 1);
      end
    end
    chk($sformatf("results_p%0d", p), got, nwant);
  endtask

  initial begin
    int k;
    int c0;
    int nv0;
    reset_n = 1'b0;
    enable  = 1'b0;
    sig_in  = 1'b0;
    step();
    step();
    chk("rst_freq", freq_hz, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovr", overrange, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_busy", busy, 0);
    reset_n = 1'b1;
    step();

    run_meas(50, 2);
    run_meas(17, 2);
    run_meas(10, 2);
    run_meas(999, 2);
    repeat (10) run_meas(int'($urandom_range(10, 900)), 2);

    enable  = 1'b0;
    wave_on = 1'b0;
    sig_in  = 1'b0;
    step();
    step();
    enable = 1'b1;
    k = 0;
    do begin
      step();
      k++;
    end while (!valid && k < 3000);
    chk("to_latency", k, TO + 1);
    chk("to_freq", freq_hz, 0);
    chk("to_flag", timeout, 1);
    chk("to_ovr", overrange, 0);
    k = 0;
    do begin
      step();
      k++;
    end while (!valid && k < 3000);
    chk("to_rearm", k, TO);

    enable = 1'b0;
    step();
    per = 50;
    hi  = 25;
    ph  = 0;
    wave_on = 1'b1;
    enable  = 1'b1;
    nv0 = nval;
    step();
    c0 = last_rise;
    while (cyc < c0 + 70) step();
    enable = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    repeat (150) step();
    chk("abort_novalid", nval - nv0, 0);
    chk("abort_freq_hold", freq_hz, 0);
    chk("abort_tmo_hold", timeout, 1);

    run_meas(50, 1);
    repeat (30) step();
    chk("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    wave_on = 1'b0;
    sig_in  = 1'b0;
    #1;
    chk("mid_rst_freq", freq_hz, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_ovr", overrange, 0);
    chk("mid_rst_tmo", timeout, 0);
    chk("mid_rst_busy", busy, 0);
    step();
    step();
    reset_n = 1'b1;
    run_meas(50, 2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
